// File: rtl/factor_sequencer.sv
// Iterative prime factorisation of a 7-bit number: one value in over valid/ready,
// its prime factors out in ascending order over valid/ready, last beat flagged.

// Combinational divisibility flags: factors[k] is set when number is divisible by k+2.
module factorizer (
   input  logic [6:0] number,
   output logic [5:0] factors
);

   always_comb begin
      factors = '0;
      for (int k = 0; k < 6; k++) begin
         factors[k] = ((number % 7'(k + 2)) == 7'd0);
      end
   end

endmodule

module factor_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [6:0] in_number,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [6:0] out_factor,
   output logic [2:0] out_index,
   output logic       out_last,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      EMIT
   } state_t;

   state_t state;
   state_t next_state;

   logic [6:0] val;
   logic [5:0] factors;
   logic [6:0] div_p;
   logic [6:0] div_q;
   logic       accept;
   logic       beat_done;
   logic       unused_composite;

   factorizer u_factorizer (
      .number  (val),
      .factors (factors)
   );

   // Divisibility by 4 and 6 is already covered by the flags for 2 and 3.
   assign unused_composite = factors[2] ^ factors[4];

   assign accept    = in_valid && (state == IDLE);
   assign beat_done = (state == EMIT) && out_ready;

   // Smallest prime divisor of val and the exact quotient; 0 and 1 pass through.
   // After 2..7 are ruled out, the only composite left below 128 is 121.
   always_comb begin
      div_p = val;
      div_q = 7'd1;
      if (val > 7'd1) begin
         if (factors[0]) begin
            div_p = 7'd2;
            div_q = val >> 1;
         end else if (factors[1]) begin
            div_p = 7'd3;
            div_q = val / 7'd3;
         end else if (factors[3]) begin
            div_p = 7'd5;
            div_q = val / 7'd5;
         end else if (factors[5]) begin
            div_p = 7'd7;
            div_q = val / 7'd7;
         end else if ((val % 7'd11) == 7'd0) begin
            div_p = 7'd11;
            div_q = val / 7'd11;
         end else begin
            div_p = val;
            div_q = 7'd1;
         end
      end
   end

   // State register; reset abandons any stream in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one CHECK cycle per factor, then hold in EMIT until taken.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = CHECK;
         CHECK:   next_state = EMIT;
         EMIT:    if (beat_done) next_state = out_last ? IDLE : CHECK;
         default: next_state = IDLE;
      endcase
   end

   // Working value and beat registers; all hold while EMIT is back-pressured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val        <= 7'd0;
         out_factor <= 7'd0;
         out_index  <= 3'd0;
         out_last   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  val       <= in_number;
                  out_index <= 3'd0;
                  out_last  <= 1'b0;
               end
            end
            CHECK: begin
               out_factor <= div_p;
               val        <= div_q;
               out_last   <= (div_q == 7'd1);
            end
            EMIT: begin
               if (beat_done && !out_last) begin
                  out_index <= out_index + 3'd1;
               end
            end
            default: begin
               val <= val;
            end
         endcase
      end
   end

   // Handshake outputs decode straight from state, so no input-to-output paths exist.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == EMIT);
      busy      = (state != IDLE);
   end

endmodule

// File: tb/tb_factor_sequencer.sv
// Bench for factor_sequencer: directed table of known factorisations, hand-written
// backpressure / ignored-input / mid-stream reset sequences, and random numbers.
module tb_factor_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_number;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] out_factor;
   logic [2:0] out_index;
   logic       out_last;
   logic       busy;

   int checks;
   int fails;
   int expq[$];

   typedef struct {
      logic [6:0] num;
      int         cnt;
      int         f[6];
      int         holdBeat;
      int         holdCycles;
   } vec_t;

   vec_t vecs[8];

   factor_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_number  (in_number),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_factor (out_factor),
      .out_index  (out_index),
      .out_last   (out_last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: plain trial division, smallest divisor first.
   function automatic void model(input int n);
      int x;
      int d;
      expq.delete();
      if (n <= 1) begin
         expq.push_back(n);
      end else begin
         x = n;
         d = 2;
         while (x > 1) begin
            if (x % d == 0) begin
               expq.push_back(d);
               x = x / d;
            end else begin
               d++;
            end
         end
      end
   endfunction

   // Feeds one number and consumes its whole stream, checking every beat against expq.
   task automatic applyStimulus(input logic [6:0] n, input bit randomReady,
                                input int holdBeat, input int holdCycles, input bit intrude);
      int  cyc;
      int  waited;
      int  held;
      bit  done;
      bit  seen;
      bit  timing;
      timing = !randomReady && (holdBeat < 0);
      @(negedge clk);
      checkOutput("idle_in_ready", int'(in_ready), 1);
      in_valid  = 1'b1;
      in_number = n;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      checkOutput("check_busy", int'(busy), 1);
      checkOutput("check_out_valid", int'(out_valid), 0);
      checkOutput("check_in_ready", int'(in_ready), 0);
      for (int i = 0; i < expq.size(); i++) begin
         waited = 0;
         held   = 0;
         done   = 1'b0;
         seen   = 1'b0;
         while (!done) begin
            if (intrude) begin
               in_valid  = (cyc == 1 || cyc == 2);
               in_number = 7'd77;
               if (in_valid) checkOutput("intrude_in_ready", int'(in_ready), 0);
            end
            if (out_valid) begin
               checkOutput($sformatf("n%0d_beat%0d_factor", n, i), int'(out_factor), expq[i]);
               checkOutput($sformatf("n%0d_beat%0d_index", n, i), int'(out_index), i);
               checkOutput($sformatf("n%0d_beat%0d_last", n, i), int'(out_last),
                           (i == expq.size() - 1) ? 1 : 0);
               if (timing && !seen) checkOutput($sformatf("n%0d_beat%0d_latency", n, i), cyc, 2 + 2 * i);
               seen = 1'b1;
               if (i == holdBeat && held < holdCycles) begin
                  out_ready = 1'b0;
                  held++;
               end else begin
                  out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
               end
               if (out_ready) done = 1'b1;
            end else begin
               out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            waited++;
            if (waited > 40) begin
               checks++;
               fails++;
               $display("[TB] FAIL beat_timeout: number %0d beat %0d got no handshake, expected one within 40 cycles", n, i);
               in_valid  = 1'b0;
               out_ready = 1'b1;
               return;
            end
            @(negedge clk);
            cyc++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("done_in_ready", int'(in_ready), 1);
      checkOutput("done_busy", int'(busy), 0);
      checkOutput("done_out_valid", int'(out_valid), 0);
   endtask

   function automatic vec_t mkvec(input logic [6:0] num, input int cnt, input int a, input int b,
                                  input int c, input int hb, input int hc);
      vec_t v;
      v.num = num;
      v.cnt = cnt;
      for (int k = 0; k < 6; k++) v.f[k] = a;
      v.f[1] = b;
      v.f[2] = c;
      v.holdBeat   = hb;
      v.holdCycles = hc;
      return v;
   endfunction

   initial begin
      logic [6:0] rn;
      checks    = 0;
      fails     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_number = 7'd0;
      out_ready = 1'b1;

      vecs[0] = mkvec(7'd12,  3, 2,  2,  3, -1, 0);
      vecs[1] = mkvec(7'd97,  1, 97, 0,  0, -1, 0);
      vecs[2] = mkvec(7'd121, 2, 11, 11, 0, -1, 0);
      vecs[3] = mkvec(7'd64,  6, 2,  2,  2, -1, 0);
      vecs[4] = mkvec(7'd0,   1, 0,  0,  0, -1, 0);
      vecs[5] = mkvec(7'd1,   1, 1,  0,  0, -1, 0);
      vecs[6] = mkvec(7'd30,  3, 2,  3,  5, 1, 5);
      vecs[7] = mkvec(7'd105, 3, 3,  5,  7, -1, 0);
      vecs[7].f[0] = 3;

      #12;
      checkOutput("reset_in_ready", int'(in_ready), 1);
      checkOutput("reset_out_valid", int'(out_valid), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_out_factor", int'(out_factor), 0);
      checkOutput("reset_out_index", int'(out_index), 0);
      checkOutput("reset_out_last", int'(out_last), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         expq.delete();
         for (int j = 0; j < vecs[v].cnt; j++) expq.push_back(vecs[v].f[j]);
         applyStimulus(vecs[v].num, 1'b0, vecs[v].holdBeat, vecs[v].holdCycles, 1'b0);
      end

      // Stray in_valid with 77 during the 12 stream must be ignored, then 77 runs normally.
      expq = '{2, 2, 3};
      applyStimulus(7'd12, 1'b0, -1, 0, 1'b1);
      expq = '{7, 11};
      applyStimulus(7'd77, 1'b0, -1, 0, 1'b0);

      // Asynchronous reset in the middle of the 60 stream.
      @(negedge clk);
      in_valid  = 1'b1;
      in_number = 7'd60;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("rst60_out_valid_before", int'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst60_out_valid", int'(out_valid), 0);
      checkOutput("rst60_busy", int'(busy), 0);
      checkOutput("rst60_in_ready", int'(in_ready), 1);
      checkOutput("rst60_out_factor", int'(out_factor), 0);
      checkOutput("rst60_out_index", int'(out_index), 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      expq = '{3, 3};
      applyStimulus(7'd9, 1'b0, -1, 0, 1'b0);

      for (int r = 0; r < 25; r++) begin
         rn = 7'($urandom_range(0, 127));
         model(int'(rn));
         applyStimulus(rn, 1'b1, -1, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
